// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and divider helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   // Clocks per oversample tick, never below one.
   function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
      longint d;
      d = clk_freq / (baud * os);
      return (d < 1) ? 1 : int'(d);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver to RX FIFO write port
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  fifo_full;

   modport master (output wr_en, output wr_data, input fifo_full);
   modport slave  (input wr_en, input wr_data, output fifo_full);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator
module uart_baud_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rstn,
   output logic tick
);
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver feeding the RX FIFO
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_WIDTH = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_in,
   uart_rx_if.master  fifo,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun_err,
   output logic       busy
);
   localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

   logic                  tick;
   logic [1:0]            sync;
   logic                  rx_s;
   rx_state_t             state, state_next;
   logic [OS_W-1:0]       os_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_bit;
   logic                  os_mid, os_last, par_bad;
   logic                  os_clr, bit_clr, shift_en, par_ld;
   logic                  wr_set, fe_set, pe_set, oe_set;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk  (clk),
      .rstn (rstn),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         sync <= 2'b11;
      else
         sync <= {sync[0], rx_in};
   end
   assign rx_s = sync[1];

   assign os_mid  = (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
   assign os_last = (os_cnt == OS_W'(OVERSAMPLE - 1));
   assign par_bad = PARITY_EN && ((^shreg ^ par_bit) != PARITY_ODD);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      os_clr     = 1'b0;
      bit_clr    = 1'b0;
      shift_en   = 1'b0;
      par_ld     = 1'b0;
      wr_set     = 1'b0;
      fe_set     = 1'b0;
      pe_set     = 1'b0;
      oe_set     = 1'b0;
      case (state)
         IDLE: begin
            if (tick && !rx_s) begin
               state_next = START;
               os_clr     = 1'b1;
            end
         end
         START: begin
            // Start bit must still be low at its midpoint, otherwise it was a glitch.
            if (tick && os_mid) begin
               if (!rx_s) begin
                  state_next = DATA;
                  os_clr     = 1'b1;
                  bit_clr    = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (tick && os_last) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_W'(DATA_WIDTH - 1))
                  state_next = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick && os_last) begin
               par_ld     = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (tick && os_last) begin
               if (!rx_s) begin
                  fe_set     = 1'b1;
                  state_next = BREAK;
               end else begin
                  state_next = IDLE;
                  if (par_bad)
                     pe_set = 1'b1;
                  else if (fifo.fifo_full)
                     oe_set = 1'b1;
                  else
                     wr_set = 1'b1;
               end
            end
         end
         BREAK: begin
            if (rx_s)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         os_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         if (os_clr || state == IDLE)
            os_cnt <= '0;
         else if (tick)
            os_cnt <= os_last ? '0 : os_cnt + OS_W'(1);

         if (bit_clr)
            bit_cnt <= '0;
         else if (shift_en)
            bit_cnt <= bit_cnt + BIT_W'(1);

         // LSB arrives first, so shifting right leaves it in bit 0 at the end.
         if (shift_en)
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};

         if (par_ld)
            par_bit <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fifo.wr_en   <= 1'b0;
         fifo.wr_data <= '0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         fifo.wr_en  <= wr_set;
         frame_err   <= fe_set;
         parity_err  <= pe_set;
         overrun_err <= oe_set;
         if (wr_set)
            fifo.wr_data <= shreg;
      end
   end
endmodule
